// File: rtl/branch_resolve_bp.sv
// Branch resolution unit for RV32 B-type branches with a bimodal (2-bit counter) predictor.
// Result, mispredict flag and statistics are registered one cycle after issue.
module branch_resolve_bp #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 16,
  parameter int CNT_W       = 16,
  parameter int PCINC       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   fetch_pc,
  output logic              pred_taken,
  input  logic              in_valid,
  input  logic [31:0]       idata,
  input  logic [XLEN-1:0]   iaddr,
  input  logic [XLEN-1:0]   imm,
  input  logic [XLEN-1:0]   rv1,
  input  logic [XLEN-1:0]   rv2,
  input  logic              in_pred_taken,
  output logic              out_valid,
  output logic [XLEN-1:0]   iaddr_val,
  output logic              taken,
  output logic              mispredict,
  output logic              illegal,
  output logic [CNT_W-1:0]  br_count,
  output logic [CNT_W-1:0]  mp_count
);

  localparam int         IDX_W     = $clog2(BHT_ENTRIES);
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] upd_idx;
  logic [2:0]       funct3;
  logic             accept;
  logic             legal;
  logic             cond;
  logic             mp_next;
  logic [XLEN-1:0]  seq_pc;
  logic [XLEN-1:0]  tgt_pc;
  logic [XLEN-1:0]  next_pc;
  logic             unused_bits;

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic up);
    logic [1:0] res;
    if (up) begin
      res = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
    end else begin
      res = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
    end
    return res;
  endfunction

  assign fetch_idx   = fetch_pc[IDX_W+1:2];
  assign upd_idx     = iaddr[IDX_W+1:2];
  // Read-before-write falls out naturally: the table only changes at the clock edge.
  assign pred_taken  = bht[fetch_idx][1];
  assign unused_bits = ^{fetch_pc[XLEN-1:IDX_W+2], fetch_pc[1:0], idata[31:15], idata[11:7]};

  // Branch condition decode, target selection and mispredict detection.
  always_comb begin
    funct3  = idata[14:12];
    accept  = in_valid && (idata[6:0] == OP_BRANCH);
    legal   = 1'b1;
    cond    = 1'b0;
    case (funct3)
      3'b000:  cond = (rv1 == rv2);
      3'b001:  cond = (rv1 != rv2);
      3'b100:  cond = ($signed(rv1) < $signed(rv2));
      3'b101:  cond = ($signed(rv1) >= $signed(rv2));
      3'b110:  cond = (rv1 < rv2);
      3'b111:  cond = (rv1 >= rv2);
      default: begin
        legal = 1'b0;
        cond  = 1'b0;
      end
    endcase
    seq_pc  = iaddr + XLEN'(PCINC);
    tgt_pc  = iaddr + imm;
    next_pc = cond ? tgt_pc : seq_pc;
    mp_next = legal && (cond != in_pred_taken);
  end

  // Result registers, predictor table and saturating statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= 2'b01;
      end
      out_valid  <= 1'b0;
      iaddr_val  <= {XLEN{1'b0}};
      taken      <= 1'b0;
      mispredict <= 1'b0;
      illegal    <= 1'b0;
      br_count   <= {CNT_W{1'b0}};
      mp_count   <= {CNT_W{1'b0}};
    end else begin
      out_valid <= accept;
      if (accept) begin
        iaddr_val  <= next_pc;
        taken      <= cond;
        mispredict <= mp_next;
        illegal    <= !legal;
        if (legal) begin
          bht[upd_idx] <= sat_update(bht[upd_idx], cond);
          if (br_count != {CNT_W{1'b1}}) begin
            br_count <= br_count + CNT_W'(1);
          end
          if (mp_next && (mp_count != {CNT_W{1'b1}})) begin
            mp_count <= mp_count + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_bp.sv
// Directed self-checking bench for branch_resolve_bp: hand-computed results, predictor
// state observed through pred_taken.
module tb_branch_resolve_bp;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic        in_valid;
  logic [31:0] idata;
  logic [31:0] iaddr;
  logic [31:0] imm;
  logic [31:0] rv1;
  logic [31:0] rv2;
  logic        in_pred_taken;
  logic        out_valid;
  logic [31:0] iaddr_val;
  logic        taken;
  logic        mispredict;
  logic        illegal;
  logic [15:0] br_count;
  logic [15:0] mp_count;

  int nvec  = 0;
  int nfail = 0;

  branch_resolve_bp dut (
    .clk(clk), .reset(reset), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
    .in_valid(in_valid), .idata(idata), .iaddr(iaddr), .imm(imm),
    .rv1(rv1), .rv2(rv2), .in_pred_taken(in_pred_taken),
    .out_valid(out_valid), .iaddr_val(iaddr_val), .taken(taken),
    .mispredict(mispredict), .illegal(illegal),
    .br_count(br_count), .mp_count(mp_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [2:0] f3);
    return {17'd0, f3, 5'd0, 7'b1100011};
  endfunction

  task automatic drive(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] im,
                       input logic [31:0] a, input logic [31:0] b, input logic pt);
    in_valid      = 1'b1;
    idata         = enc(f3);
    iaddr         = pc;
    imm           = im;
    rv1           = a;
    rv2           = b;
    in_pred_taken = pt;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic ov, input logic tk, input logic [31:0] nx,
                         input logic mp, input logic il, input int bc, input int mc);
    check({tag, ".out_valid"},  {31'd0, out_valid},  {31'd0, ov});
    check({tag, ".taken"},      {31'd0, taken},      {31'd0, tk});
    check({tag, ".iaddr_val"},  iaddr_val,           nx);
    check({tag, ".mispredict"}, {31'd0, mispredict}, {31'd0, mp});
    check({tag, ".illegal"},    {31'd0, illegal},    {31'd0, il});
    check({tag, ".br_count"},   {16'd0, br_count},   bc);
    check({tag, ".mp_count"},   {16'd0, mp_count},   mc);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; idata = 32'd0; iaddr = 32'd0; imm = 32'd0;
    rv1 = 32'd0; rv2 = 32'd0; in_pred_taken = 1'b0; fetch_pc = 32'd0;

    // A request during reset is discarded.
    drive(3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0);
    tick;
    tick;
    chk_res("reset", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 0, 0);
    check("reset.pred", {31'd0, pred_taken}, 32'd0);
    reset = 1'b0;

    drive(3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0);
    tick;
    chk_res("beq", 1'b1, 1'b1, 32'h120, 1'b1, 1'b0, 1, 1);
    check("beq.pred", {31'd0, pred_taken}, 32'd1);

    tick;
    check("idle.out_valid", {31'd0, out_valid}, 32'd0);
    check("idle.hold", iaddr_val, 32'h120);

    // Signedness: rv1=-1, rv2=1, all at BHT index 1.
    drive(3'b100, 32'h204, 32'h10, 32'hFFFF_FFFF, 32'd1, 1'b1);
    tick;
    chk_res("blt", 1'b1, 1'b1, 32'h214, 1'b0, 1'b0, 2, 1);
    drive(3'b110, 32'h204, 32'h10, 32'hFFFF_FFFF, 32'd1, 1'b0);
    tick;
    chk_res("bltu", 1'b1, 1'b0, 32'h208, 1'b0, 1'b0, 3, 1);
    drive(3'b101, 32'h204, 32'h10, 32'hFFFF_FFFF, 32'd1, 1'b1);
    tick;
    chk_res("bge", 1'b1, 1'b0, 32'h208, 1'b1, 1'b0, 4, 2);
    drive(3'b111, 32'h204, 32'h10, 32'hFFFF_FFFF, 32'd1, 1'b1);
    tick;
    chk_res("bgeu", 1'b1, 1'b1, 32'h214, 1'b0, 1'b0, 5, 2);
    fetch_pc = 32'h204;
    #1;
    check("idx1.pred", {31'd0, pred_taken}, 32'd0);

    // Saturation at 0x40 (index 0, currently 2'b10).
    fetch_pc = 32'h40;
    for (int i = 0; i < 4; i++) begin
      drive(3'b000, 32'h40, 32'h100, 32'd0, 32'd0, 1'b1);
      tick;
      chk_res("sat_t", 1'b1, 1'b1, 32'h140, 1'b0, 1'b0, 6 + i, 2);
      check("sat_t.pred", {31'd0, pred_taken}, 32'd1);
    end
    drive(3'b001, 32'h40, 32'h100, 32'd0, 32'd0, 1'b1);
    tick;
    chk_res("sat_nt", 1'b1, 1'b0, 32'h44, 1'b1, 1'b0, 10, 3);
    check("sat_nt.pred", {31'd0, pred_taken}, 32'd1);

    // Read-before-write on index 0 with counter 2'b10.
    drive(3'b001, 32'h40, 32'h100, 32'd7, 32'd7, 1'b1);
    #1;
    check("rbw.before", {31'd0, pred_taken}, 32'd1);
    tick;
    chk_res("rbw", 1'b1, 1'b0, 32'h44, 1'b1, 1'b0, 11, 4);
    check("rbw.after", {31'd0, pred_taken}, 32'd0);

    drive(3'b010, 32'h300, 32'h40, 32'd1, 32'd1, 1'b1);
    tick;
    chk_res("ill010", 1'b1, 1'b0, 32'h304, 1'b0, 1'b1, 11, 4);
    check("ill010.pred", {31'd0, pred_taken}, 32'd0);
    drive(3'b011, 32'h300, 32'h40, 32'd2, 32'd9, 1'b0);
    tick;
    chk_res("ill011", 1'b1, 1'b0, 32'h304, 1'b0, 1'b1, 11, 4);

    drive(3'b000, 32'h500, 32'h8, 32'd3, 32'd3, 1'b0);
    idata = 32'h0000_0033;
    tick;
    chk_res("ignore", 1'b0, 1'b0, 32'h304, 1'b0, 1'b1, 11, 4);
    check("ignore.pred", {31'd0, pred_taken}, 32'd0);

    // Address wrap at the top of the address space (index 15).
    fetch_pc = 32'hFFFF_FFFC;
    drive(3'b111, 32'hFFFF_FFFC, 32'h8, 32'd3, 32'd3, 1'b1);
    tick;
    chk_res("wrap_t", 1'b1, 1'b1, 32'h4, 1'b0, 1'b0, 12, 4);
    check("wrap_t.pred", {31'd0, pred_taken}, 32'd1);
    drive(3'b001, 32'hFFFF_FFFC, 32'h8, 32'd3, 32'd3, 1'b0);
    tick;
    chk_res("wrap_nt", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 13, 4);
    check("wrap_nt.pred", {31'd0, pred_taken}, 32'd0);

    // Reset in the middle of a branch stream.
    fetch_pc = 32'h40;
    drive(3'b000, 32'h40, 32'h10, 32'd1, 32'd1, 1'b0);
    tick;
    chk_res("pre_rst", 1'b1, 1'b1, 32'h50, 1'b1, 1'b0, 14, 5);
    check("pre_rst.pred", {31'd0, pred_taken}, 32'd1);
    reset = 1'b1;
    drive(3'b000, 32'h40, 32'h10, 32'd1, 32'd1, 1'b0);
    tick;
    reset = 1'b0;
    chk_res("mid_rst", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 0, 0);
    check("mid_rst.pred", {31'd0, pred_taken}, 32'd0);
    drive(3'b000, 32'h40, 32'h10, 32'd1, 32'd1, 1'b1);
    tick;
    chk_res("post_rst", 1'b1, 1'b1, 32'h50, 1'b0, 1'b0, 1, 0);
    check("post_rst.pred", {31'd0, pred_taken}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_bp.md
# branch_resolve_bp

Parametrised branch unit with a built-in bimodal predictor. Resolves RV32 B-type conditional branches (opcode 7'b1100011) with correct signed/unsigned compares. Maintains a table of 2-bit saturating counters that the fetch stage reads for a taken/not-taken prediction, registers the resolved next-PC and the mispredict flag one cycle after issue, and keeps saturating statistics counters. Sits between decode/register-read and the PC-select logic.

## Interface
- XLEN, 32, data/address width
- BHT_ENTRIES, 16, predictor entries; power of two, ≥2; IDX_W = log2(BHT_ENTRIES)
- CNT_W, 16, width of statistics counters
- PCINC, 4, sequential PC increment

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- fetch_pc  in  XLEN  PC being fetched; predictor lookup address
- pred_taken  out  1  combinational prediction: MSB of BHT[fetch_pc[IDX_W+1:2]]
- in_valid  in  1  resolve request this cycle
- idata  in  32  instruction word
- iaddr  in  XLEN  PC of the instruction
- imm  in  XLEN  sign-extended B-immediate
- rv1, rv2  in  XLEN  source operand values
- in_pred_taken  in  1  prediction fetch used for this instruction
- out_valid  out  1  registered result valid, one-cycle pulse per accepted request
- iaddr_val  out  XLEN  resolved next PC
- taken  out  1  branch condition outcome
- mispredict  out  1  taken != in_pred_taken; PC-select must redirect to iaddr_val
- illegal  out  1  branch opcode with reserved funct3
- br_count  out  CNT_W  resolved legal branches, saturating
- mp_count  out  CNT_W  mispredicted branches, saturating

## Operation
- Accept: in_valid=1 and idata[6:0]=7'b1100011. Any other opcode is ignored: no output pulse, no state change.
- funct3 = idata[14:12]:
  - 000 BEQ: rv1==rv2
  - 001 BNE: rv1!=rv2
  - 100 BLT: signed rv1<rv2
  - 101 BGE: signed rv1>=rv2
  - 110 BLTU: unsigned rv1<rv2
  - 111 BGEU: unsigned rv1>=rv2
- Next PC: iaddr_val = taken ? iaddr+imm : iaddr+PCINC. Both sums are modulo 2^XLEN and wrap silently.
- Reserved funct3 (010, 011):
  - Outputs: out_valid=1, illegal=1, taken=0, mispredict=0, iaddr_val=iaddr+PCINC.
  - No BHT or counter update.
- BHT: index = iaddr[IDX_W+1:2]. On a legal accepted branch, the counter increments if taken and decrements if not, saturating at 2'b11 and 2'b00.
- Statistics: br_count increments per legal branch. mp_count increments when mispredict=1. Both hold at all-ones.
- Non-branch cycles: out_valid=0. The other registered outputs hold their last value.

## Timing
- Latency: request in cycle N gives registered outputs valid in cycle N+1. Throughput is one branch per cycle. There is no backpressure.
- BHT update takes effect at the edge ending cycle N; pred_taken reflects it from cycle N+1.
- Same index read and updated in the same cycle: pred_taken returns the pre-update value (read-before-write).
- Reset, applied in any cycle including mid-stream:
  - Next edge sets all BHT entries to 2'b01 (weakly not-taken).
  - out_valid, iaddr_val, taken, mispredict, illegal, br_count and mp_count go to 0.
  - A request presented in the reset cycle is discarded.
  - pred_taken=0 after reset.
- Back-to-back branches to the same index: each update builds on the previous one, with no lost updates.

## Test plan
- Reset then BEQ: iaddr=0x100, imm=0x20, rv1=rv2=5, in_pred_taken=0 -> next cycle out_valid=1, taken=1, iaddr_val=0x120, mispredict=1, br_count=1, mp_count=1, BHT[0] (iaddr[5:2]=0) = 2'b10.
- Signedness: rv1=0xFFFFFFFF, rv2=1 -> BLT taken, BLTU not taken (iaddr_val=iaddr+4), BGE not taken, BGEU taken.
- Saturation: four consecutive taken branches at iaddr=0x40 -> counter reaches 2'b11 and stays; pred_taken=1 for fetch_pc=0x40; one not-taken -> 2'b10, pred_taken still 1.
- Read-before-write: fetch_pc=0x40 while resolving a not-taken branch at 0x40 with counter 2'b10 -> pred_taken=1 this cycle, 0 next cycle.
- Illegal/ignored: funct3=010 -> illegal=1, iaddr_val=iaddr+4, counters unchanged. Opcode 0110011 with in_valid=1 -> out_valid=0.
- Wrap and reset: iaddr=0xFFFFFFFC, imm=8, taken -> iaddr_val=0x4. Reset asserted during a stream of branches -> all outputs 0 next cycle and BHT back to 2'b01.
